// File: rtl/rand_walk_integrator_if.sv
// CPU snapshot read port for rand_walk_integrator: level request, coherent pos/vel reply.
interface rand_walk_integrator_if #(
  parameter int POS_W = 10,
  parameter int VEL_W = 6
);
  logic             rd_req;
  logic             rd_valid;
  logic [POS_W-1:0] rd_pos;
  logic [VEL_W-1:0] rd_vel;

  modport master (output rd_req, input rd_valid, rd_pos, rd_vel);
  modport slave  (input rd_req, output rd_valid, rd_pos, rd_vel);
endinterface

// File: rtl/rand_walk_integrator.sv
// Integrates a sampled random acceleration into bounded velocity/position with a snapshot read port.
// Optional macro RAND_WALK_BOUNCE_EN: a wall event reflects the velocity instead of zeroing it.
module rand_walk_integrator #(
  parameter int POS_W    = 10,
  parameter int POS_MAX  = 639,
  parameter int POS_INIT = 320,
  parameter int VEL_W    = 6,
  parameter int VEL_MAX  = 15,
  parameter int TICK_DIV = 50000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3:0]             random_acc,
  rand_walk_integrator_if.slave  rd,
  output logic [POS_W-1:0]       pos,
  output logic [VEL_W-1:0]       vel,
  output logic                   wall_hit
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [VEL_W:0]   VEL_HI   = (VEL_W + 1)'(VEL_MAX);
  localparam logic signed [VEL_W:0]   VEL_LO   = -VEL_HI;
  localparam logic signed [POS_W+1:0] POS_HI   = (POS_W + 2)'(POS_MAX);

  typedef enum logic [1:0] {S_WAIT, S_ACCEL, S_MOVE, S_PUBLISH} state_t;

  state_t                  r_state, w_state_n;
  logic [CNT_W-1:0]        r_cnt;
  logic [3:0]              r_acc, w_acc_n;
  logic [POS_W-1:0]        r_pos_i, w_pos_i_n, r_pos;
  logic [VEL_W-1:0]        r_vel_i, w_vel_i_n, r_vel;
  logic                    r_wall_hit, w_wall;
  logic                    r_rd_valid;
  logic [POS_W-1:0]        r_rd_pos;
  logic [VEL_W-1:0]        r_rd_vel;
  logic signed [VEL_W:0]   w_acc_ext, w_vsum;
  logic signed [POS_W+1:0] w_psum;

  // The -8 code is outside the generator's legal range and counts as no acceleration.
  assign w_acc_ext = (r_acc == 4'b1000) ? '0 : (VEL_W + 1)'($signed(r_acc));
  assign w_vsum    = (VEL_W + 1)'($signed(r_vel_i)) + w_acc_ext;
  assign w_psum    = $signed({2'b00, r_pos_i}) + (POS_W + 2)'($signed(r_vel_i));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_pos_i_n = r_pos_i;
    w_vel_i_n = r_vel_i;
    w_wall    = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (enable && (r_cnt == CNT_LAST)) begin
          w_acc_n   = random_acc;
          w_state_n = S_ACCEL;
        end
      end
      S_ACCEL: begin
        if (w_vsum > VEL_HI)      w_vel_i_n = VEL_HI[VEL_W-1:0];
        else if (w_vsum < VEL_LO) w_vel_i_n = VEL_LO[VEL_W-1:0];
        else                      w_vel_i_n = w_vsum[VEL_W-1:0];
        w_state_n = S_MOVE;
      end
      S_MOVE: begin
        if (w_psum[POS_W+1]) begin
          w_pos_i_n = '0;
          w_wall    = 1'b1;
        end else if (w_psum > POS_HI) begin
          w_pos_i_n = POS_HI[POS_W-1:0];
          w_wall    = 1'b1;
        end else begin
          w_pos_i_n = w_psum[POS_W-1:0];
        end
        if (w_wall) begin
`ifdef RAND_WALK_BOUNCE_EN
          w_vel_i_n = -r_vel_i;
`else
          w_vel_i_n = '0;
`endif
        end
        w_state_n = S_PUBLISH;
      end
      S_PUBLISH: w_state_n = S_WAIT;
      default:   w_state_n = S_WAIT;
    endcase
  end

  // The tick counter keeps running through a step so sample edges stay TICK_DIV apart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_pos_i    <= POS_W'(POS_INIT);
      r_vel_i    <= '0;
      r_pos      <= POS_W'(POS_INIT);
      r_vel      <= '0;
      r_wall_hit <= 1'b0;
    end else begin
      if (enable) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      r_acc      <= w_acc_n;
      r_pos_i    <= w_pos_i_n;
      r_vel_i    <= w_vel_i_n;
      r_wall_hit <= w_wall;
      if (r_state == S_PUBLISH) begin
        r_pos <= r_pos_i;
        r_vel <= r_vel_i;
      end
    end
  end

  // Snapshot only ever copies the published registers, so a PUBLISH edge yields the old pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_pos   <= POS_W'(POS_INIT);
      r_rd_vel   <= '0;
    end else if (rd.rd_req && !r_rd_valid) begin
      r_rd_valid <= 1'b1;
      r_rd_pos   <= r_pos;
      r_rd_vel   <= r_vel;
    end else if (!rd.rd_req) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign pos         = r_pos;
  assign vel         = r_vel;
  assign wall_hit    = r_wall_hit;
  assign rd.rd_valid = r_rd_valid;
  assign rd.rd_pos   = r_rd_pos;
  assign rd.rd_vel   = r_rd_vel;

endmodule

// File: tb/tb_rand_walk_integrator.sv
// Directed self-checking bench for rand_walk_integrator: three instances (start 320, 630, 2), TICK_DIV=4.
module tb_rand_walk_integrator;

  localparam int POS_W = 10;
  localparam int VEL_W = 6;

`ifdef RAND_WALK_BOUNCE_EN
  localparam logic [VEL_W-1:0] WALL_UP_VEL = 6'b110010;
  localparam logic [VEL_W-1:0] WALL_LO_VEL = 6'd7;
`else
  localparam logic [VEL_W-1:0] WALL_UP_VEL = 6'd0;
  localparam logic [VEL_W-1:0] WALL_LO_VEL = 6'd0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enA = 1'b0, enB = 1'b0, enC = 1'b0;
  logic [3:0] accA = 4'd0, accB = 4'd0, accC = 4'd0;
  logic [POS_W-1:0] posA, posB, posC;
  logic [VEL_W-1:0] velA, velB, velC;
  logic wallA, wallB, wallC;
  int checks = 0;
  int errors = 0;

  rand_walk_integrator_if #(.POS_W(POS_W), .VEL_W(VEL_W)) ifA ();
  rand_walk_integrator_if #(.POS_W(POS_W), .VEL_W(VEL_W)) ifB ();
  rand_walk_integrator_if #(.POS_W(POS_W), .VEL_W(VEL_W)) ifC ();

  rand_walk_integrator #(.POS_W(POS_W), .POS_MAX(639), .POS_INIT(320), .VEL_W(VEL_W),
                         .VEL_MAX(15), .TICK_DIV(4)) dutA (
    .clock(clock), .reset(reset), .enable(enA), .random_acc(accA), .rd(ifA),
    .pos(posA), .vel(velA), .wall_hit(wallA));

  rand_walk_integrator #(.POS_W(POS_W), .POS_MAX(639), .POS_INIT(630), .VEL_W(VEL_W),
                         .VEL_MAX(15), .TICK_DIV(4)) dutB (
    .clock(clock), .reset(reset), .enable(enB), .random_acc(accB), .rd(ifB),
    .pos(posB), .vel(velB), .wall_hit(wallB));

  rand_walk_integrator #(.POS_W(POS_W), .POS_MAX(639), .POS_INIT(2), .VEL_W(VEL_W),
                         .VEL_MAX(15), .TICK_DIV(4)) dutC (
    .clock(clock), .reset(reset), .enable(enC), .random_acc(accC), .rd(ifC),
    .pos(posC), .vel(velC), .wall_hit(wallC));

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reset values while reset is held, then release with the counter at 0.
  task automatic test_reset;
    tick(2);
    checks++;
    if (posA !== 10'd320 || velA !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_posvel: got pos=%0d vel=%0d expected pos=320 vel=0", posA, velA);
    end
    checks++;
    if (ifA.rd_valid !== 1'b0 || wallA !== 1'b0 || ifA.rd_pos !== 10'd320 || ifA.rd_vel !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_rd: got valid=%0b wall=%0b rd_pos=%0d rd_vel=%0d expected 0 0 320 0",
               ifA.rd_valid, wallA, ifA.rd_pos, ifA.rd_vel);
    end
    reset = 1'b0;
  endtask

  // +3 held: samples on edges 4,8,..; each publish lands 3 edges later.
  task automatic test_constant_accel;
    logic [POS_W-1:0] expPos [6];
    logic [VEL_W-1:0] expVel [6];
    expPos = '{10'd323, 10'd329, 10'd338, 10'd350, 10'd365, 10'd380};
    expVel = '{6'd3, 6'd6, 6'd9, 6'd12, 6'd15, 6'd15};
    accA = 4'd3;
    enA  = 1'b1;
    tick(6);
    checks++;
    if (posA !== 10'd320) begin
      errors++;
      $display("[TB] FAIL accel_early: got pos=%0d expected 320", posA);
    end
    tick(1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        tick(3);
        checks++;
        if (posA !== expPos[k-1]) begin
          errors++;
          $display("[TB] FAIL accel_hold%0d: got pos=%0d expected %0d", k, posA, expPos[k-1]);
        end
        tick(1);
      end
      checks++;
      if (posA !== expPos[k] || velA !== expVel[k]) begin
        errors++;
        $display("[TB] FAIL accel_step%0d: got pos=%0d vel=%0d expected pos=%0d vel=%0d",
                 k + 1, posA, velA, expPos[k], expVel[k]);
      end
    end
  endtask

  // Reset while dutA is in ACCEL with a snapshot held; the aborted step must never publish.
  task automatic test_reset_midstep;
    ifA.rd_req = 1'b1;
    tick(1);
    checks++;
    if (ifA.rd_valid !== 1'b1 || ifA.rd_pos !== 10'd380 || ifA.rd_vel !== 6'd15) begin
      errors++;
      $display("[TB] FAIL premid_snap: got valid=%0b pos=%0d vel=%0d expected 1 380 15",
               ifA.rd_valid, ifA.rd_pos, ifA.rd_vel);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (posA !== 10'd320 || velA !== 6'd0 || ifA.rd_valid !== 1'b0 || wallA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got pos=%0d vel=%0d valid=%0b wall=%0b expected 320 0 0 0",
               posA, velA, ifA.rd_valid, wallA);
    end
    ifA.rd_req = 1'b0;
    #1 reset = 1'b0;
    tick(6);
    checks++;
    if (posA !== 10'd320 || velA !== 6'd0) begin
      errors++;
      $display("[TB] FAIL midreset_restart_early: got pos=%0d vel=%0d expected 320 0", posA, velA);
    end
    tick(1);
    checks++;
    if (posA !== 10'd323 || velA !== 6'd3) begin
      errors++;
      $display("[TB] FAIL midreset_restart: got pos=%0d vel=%0d expected 323 3", posA, velA);
    end
  endtask

  // Request raised during PUBLISH captures the pre-publish pair and holds it across two more steps.
  task automatic test_read_coherency;
    tick(3);
    ifA.rd_req = 1'b1;
    tick(1);
    checks++;
    if (ifA.rd_valid !== 1'b1 || ifA.rd_pos !== 10'd323 || ifA.rd_vel !== 6'd3 || posA !== 10'd329) begin
      errors++;
      $display("[TB] FAIL read_publish: got valid=%0b rd_pos=%0d rd_vel=%0d pos=%0d expected 1 323 3 329",
               ifA.rd_valid, ifA.rd_pos, ifA.rd_vel, posA);
    end
    tick(8);
    checks++;
    if (ifA.rd_valid !== 1'b1 || ifA.rd_pos !== 10'd323 || ifA.rd_vel !== 6'd3 ||
        posA !== 10'd350 || velA !== 6'd12) begin
      errors++;
      $display("[TB] FAIL read_hold: got valid=%0b rd_pos=%0d rd_vel=%0d pos=%0d vel=%0d expected 1 323 3 350 12",
               ifA.rd_valid, ifA.rd_pos, ifA.rd_vel, posA, velA);
    end
    ifA.rd_req = 1'b0;
    tick(1);
    checks++;
    if (ifA.rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_drop: got valid=%0b expected 0", ifA.rd_valid);
    end
    ifA.rd_req = 1'b1;
    tick(1);
    checks++;
    if (ifA.rd_valid !== 1'b1 || ifA.rd_pos !== 10'd350 || ifA.rd_vel !== 6'd12) begin
      errors++;
      $display("[TB] FAIL read_again: got valid=%0b rd_pos=%0d rd_vel=%0d expected 1 350 12",
               ifA.rd_valid, ifA.rd_pos, ifA.rd_vel);
    end
    ifA.rd_req = 1'b0;
    tick(1);
  endtask

  // Freeze at count 2 for 10 cycles, then drop enable again mid-step: that step still completes.
  task automatic test_enable_gating;
    enA = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    accA = 4'd2;
    enA  = 1'b1;
    tick(2);
    enA = 1'b0;
    tick(10);
    checks++;
    if (posA !== 10'd320 || velA !== 6'd0) begin
      errors++;
      $display("[TB] FAIL gate_frozen: got pos=%0d vel=%0d expected 320 0", posA, velA);
    end
    enA = 1'b1;
    tick(2);
    enA = 1'b0;
    tick(2);
    checks++;
    if (posA !== 10'd320) begin
      errors++;
      $display("[TB] FAIL gate_early: got pos=%0d expected 320", posA);
    end
    tick(1);
    checks++;
    if (posA !== 10'd322 || velA !== 6'd2) begin
      errors++;
      $display("[TB] FAIL gate_step: got pos=%0d vel=%0d expected 322 2", posA, velA);
    end
    tick(8);
    checks++;
    if (posA !== 10'd322 || velA !== 6'd2) begin
      errors++;
      $display("[TB] FAIL gate_paused: got pos=%0d vel=%0d expected 322 2", posA, velA);
    end
  endtask

  // The -8 code leaves velocity at 2, so position advances by 2.
  task automatic test_invalid_acc;
    accA = 4'b1000;
    enA  = 1'b1;
    tick(7);
    checks++;
    if (posA !== 10'd324 || velA !== 6'd2) begin
      errors++;
      $display("[TB] FAIL invalid_acc: got pos=%0d vel=%0d expected 324 2", posA, velA);
    end
    enA = 1'b0;
  endtask

  task automatic test_wall_upper;
    accB = 4'd7;
    enB  = 1'b1;
    tick(7);
    checks++;
    if (posB !== 10'd637 || velB !== 6'd7 || wallB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wallup_step1: got pos=%0d vel=%0d wall=%0b expected 637 7 0", posB, velB, wallB);
    end
    tick(2);
    checks++;
    if (wallB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wallup_pre: got wall=%0b expected 0", wallB);
    end
    tick(1);
    checks++;
    if (wallB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wallup_pulse: got wall=%0b expected 1", wallB);
    end
    tick(1);
    checks++;
    if (wallB !== 1'b0 || posB !== 10'd639 || velB !== WALL_UP_VEL) begin
      errors++;
      $display("[TB] FAIL wallup_step2: got wall=%0b pos=%0d vel=%0d expected 0 639 %0d",
               wallB, posB, velB, WALL_UP_VEL);
    end
    enB = 1'b0;
  endtask

  task automatic test_wall_lower;
    accC = 4'b1001;
    enC  = 1'b1;
    tick(6);
    checks++;
    if (wallC !== 1'b1 || posC !== 10'd2) begin
      errors++;
      $display("[TB] FAIL walllo_pulse: got wall=%0b pos=%0d expected 1 2", wallC, posC);
    end
    tick(1);
    checks++;
    if (wallC !== 1'b0 || posC !== 10'd0 || velC !== WALL_LO_VEL) begin
      errors++;
      $display("[TB] FAIL walllo_step: got wall=%0b pos=%0d vel=%0d expected 0 0 %0d",
               wallC, posC, velC, WALL_LO_VEL);
    end
    enC = 1'b0;
  endtask

  initial begin
    ifA.rd_req = 1'b0;
    ifB.rd_req = 1'b0;
    ifC.rd_req = 1'b0;
    test_reset;
    test_constant_accel;
    test_reset_midstep;
    test_read_coherency;
    test_enable_gating;
    test_invalid_acc;
    test_wall_upper;
    test_wall_lower;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
